// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-outstanding line fetcher feeding a
// 32-byte in-order byte buffer that the decoder drains from the front.
//
// state | meaning
// IDLE  | no request pending; wait for buffer room (cnt <= 16)
// REQ   | line request presented, waiting for memory handshake
// WAIT  | request accepted, waiting for the response strobe
// DROP  | accepted request became stale after a flush; discard its response
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         stall,
    input  logic         flush,
    input  logic [63:0]  flush_pc,
    output logic         imem_req_valid,
    output logic [63:0]  imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_resp_valid,
    input  logic [127:0] imem_resp_data,
    output logic [127:0] fet_bytes,
    output logic [4:0]   fet_count,
    output logic         fet_valid,
    output logic [63:0]  fet_pc,
    input  logic [4:0]   fet_consume
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

    state_e       state_q;
    logic [255:0] buf_q;
    logic [255:0] buf_d;
    logic [5:0]   cnt_q;
    logic [5:0]   cnt_d;
    logic [63:0]  pc_q;
    logic [63:0]  pc_d;
    logic [63:0]  faddr_q;
    logic [3:0]   skip_q;

    logic [4:0]   consume;
    logic [5:0]   cnt_kept;
    logic [255:0] kept;
    logic [255:0] line;
    logic         append;
    logic         handshake;

    // Bytes above cnt are always held at zero, so the low 16 bytes of the
    // buffer can be presented directly without masking.
    assign fet_count      = (cnt_q > 6'd16) ? 5'd16 : cnt_q[4:0];
    assign fet_valid      = (cnt_q != 6'd0);
    assign fet_bytes      = buf_q[127:0];
    assign fet_pc         = pc_q;
    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = faddr_q;
    assign handshake      = imem_req_valid & imem_req_ready;
    assign append         = (state_q == WAIT) & imem_resp_valid & ~flush;

    // Next buffer contents: drop consumed bytes from the front, then place the
    // useful part of an arriving line right behind whatever remains.
    always_comb begin
        consume = 5'd0;
        if (!stall) begin
            consume = (fet_consume > fet_count) ? fet_count : fet_consume;
        end
        cnt_kept = cnt_q - {1'b0, consume};
        kept     = buf_q >> {consume, 3'b000};
        line     = {128'h0, imem_resp_data} >> {skip_q, 3'b000};
        buf_d    = kept;
        cnt_d    = cnt_kept;
        if (append) begin
            buf_d = kept | (line << {cnt_kept, 3'b000});
            cnt_d = cnt_kept + (6'd16 - {2'b00, skip_q});
        end
        pc_d = pc_q + {59'h0, consume};
    end

    // Fetch state machine plus buffer, PC and line-address registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            faddr_q <= {RESET_PC[63:4], 4'h0};
            skip_q  <= RESET_PC[3:0];
        end else begin
            if (flush) begin
                buf_q   <= '0;
                cnt_q   <= '0;
                pc_q    <= flush_pc;
                faddr_q <= {flush_pc[63:4], 4'h0};
                skip_q  <= flush_pc[3:0];
            end else begin
                buf_q <= buf_d;
                cnt_q <= cnt_d;
                pc_q  <= pc_d;
                if (append) begin
                    faddr_q <= faddr_q + 64'd16;
                    skip_q  <= 4'h0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (flush || (cnt_q <= 6'd16)) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        // An accepted-but-now-stale request still owes a response.
                        state_q <= handshake ? DROP : REQ;
                    end else if (handshake) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_q <= imem_resp_valid ? REQ : DROP;
                    end else if (imem_resp_valid) begin
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_resp_valid) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// then randomized traffic against a byte-queue reference model.
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1003;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic [63:0]  flush_pc = '0;
    logic         imem_req_valid;
    logic [63:0]  imem_req_addr;
    logic         imem_req_ready = 1'b0;
    logic         imem_resp_valid = 1'b0;
    logic [127:0] imem_resp_data = '0;
    logic [127:0] fet_bytes;
    logic [4:0]   fet_count;
    logic         fet_valid;
    logic [63:0]  fet_pc;
    logic [4:0]   fet_consume = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .stall           (stall),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fet_bytes       (fet_bytes),
        .fet_count       (fet_count),
        .fet_valid       (fet_valid),
        .fet_pc          (fet_pc),
        .fet_consume     (fet_consume)
    );

    // Memory contents: byte value at each address.
    function automatic logic [7:0] memb(input logic [63:0] a);
        return a[7:0] ^ a[31:24] ^ a[47:40] ^ a[63:56];
    endfunction

    function automatic logic [127:0] line_data(input logic [63:0] a);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[8*k +: 8] = memb(a + 64'(k));
        return d;
    endfunction

    function automatic logic [127:0] exp_bytes(input logic [63:0] pc, input int n);
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) if (k < n) d[8*k +: 8] = memb(pc + 64'(k));
        return d;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [63:0] ea,
                               input int ec, input logic [63:0] epc);
        chk($sformatf("%s.req_valid", tag), 128'(imem_req_valid), 128'(ev));
        if (ev) chk($sformatf("%s.req_addr", tag), 128'(imem_req_addr), 128'(ea));
        chk($sformatf("%s.count", tag), 128'(fet_count), 128'(ec));
        chk($sformatf("%s.fvalid", tag), 128'(fet_valid), 128'(ec != 0));
        chk($sformatf("%s.pc", tag), 128'(fet_pc), 128'(epc));
        chk($sformatf("%s.bytes", tag), fet_bytes, exp_bytes(epc, ec));
    endtask

    task automatic apply(input logic rdy, input logic rsp, input logic [63:0] rline,
                         input logic st, input logic fl, input logic [63:0] fpc, input int cons);
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? line_data(rline) : 128'h0;
        stall           = st;
        flush           = fl;
        flush_pc        = fpc;
        fet_consume     = 5'(cons);
        @(negedge clk);
    endtask

    // One row: expected outputs seen before the row's inputs, then inputs applied.
    typedef struct {
        logic        rdy;
        logic        rsp;
        logic [63:0] rline;
        logic        st;
        logic        fl;
        logic [63:0] fpc;
        int          cons;
        logic        ev;
        logic [63:0] ea;
        int          ec;
        logic [63:0] epc;
    } vec_t;

    function automatic vec_t v(input logic rdy, input logic rsp, input logic [63:0] rline,
                               input logic st, input logic fl, input logic [63:0] fpc, input int cons,
                               input logic ev, input logic [63:0] ea, input int ec, input logic [63:0] epc);
        vec_t r;
        r.rdy = rdy; r.rsp = rsp; r.rline = rline; r.st = st; r.fl = fl; r.fpc = fpc;
        r.cons = cons; r.ev = ev; r.ea = ea; r.ec = ec; r.epc = epc;
        return r;
    endfunction

    vec_t tbl[26];

    // Reference model state for the randomized phase.
    logic [7:0]  q[$];
    logic [63:0] m_pc, m_faddr, mem_addr, fpc;
    logic [3:0]  m_skip;
    bit          m_out, m_stale, mem_busy, st, fl, rdy, rsp, hs;
    int          mem_dly, idle_run, n, ec, c, cons;
    logic [127:0] eb;

    initial begin
        //            rdy rsp rline     st fl fpc      cons  ev ea        ec  epc
        tbl[0]  = v(1, 0, 64'h0,    0, 0, 64'h0,    0,  1, 64'h1000, 0,  64'h1003);
        tbl[1]  = v(0, 1, 64'h1000, 0, 0, 64'h0,    0,  0, 64'h0,    0,  64'h1003);
        tbl[2]  = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  0, 64'h0,    13, 64'h1003);
        tbl[3]  = v(1, 0, 64'h0,    0, 0, 64'h0,    3,  1, 64'h1010, 13, 64'h1003);
        tbl[4]  = v(0, 1, 64'h1010, 0, 0, 64'h0,    0,  0, 64'h0,    10, 64'h1006);
        tbl[5]  = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  0, 64'h0,    16, 64'h1006);
        tbl[6]  = v(0, 0, 64'h0,    1, 0, 64'h0,    16, 0, 64'h0,    16, 64'h1006);
        tbl[7]  = v(0, 0, 64'h0,    0, 0, 64'h0,    9,  0, 64'h0,    16, 64'h1006);
        tbl[8]  = v(0, 0, 64'h0,    0, 0, 64'h0,    1,  0, 64'h0,    16, 64'h100F);
        tbl[9]  = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  0, 64'h0,    16, 64'h1010);
        tbl[10] = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  1, 64'h1020, 16, 64'h1010);
        tbl[11] = v(0, 0, 64'h0,    0, 1, 64'h2008, 0,  1, 64'h1020, 16, 64'h1010);
        tbl[12] = v(1, 0, 64'h0,    0, 0, 64'h0,    0,  1, 64'h2000, 0,  64'h2008);
        tbl[13] = v(0, 1, 64'h2000, 0, 0, 64'h0,    0,  0, 64'h0,    0,  64'h2008);
        tbl[14] = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  0, 64'h0,    8,  64'h2008);
        tbl[15] = v(1, 0, 64'h0,    0, 0, 64'h0,    0,  1, 64'h2010, 8,  64'h2008);
        tbl[16] = v(0, 1, 64'h2010, 0, 0, 64'h0,    0,  0, 64'h0,    8,  64'h2008);
        tbl[17] = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  0, 64'h0,    16, 64'h2008);
        tbl[18] = v(0, 0, 64'h0,    0, 0, 64'h0,    8,  0, 64'h0,    16, 64'h2008);
        tbl[19] = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  0, 64'h0,    16, 64'h2010);
        tbl[20] = v(1, 0, 64'h0,    0, 0, 64'h0,    0,  1, 64'h2020, 16, 64'h2010);
        tbl[21] = v(0, 1, 64'h2020, 0, 0, 64'h0,    5,  0, 64'h0,    16, 64'h2010);
        tbl[22] = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  0, 64'h0,    16, 64'h2015);
        tbl[23] = v(0, 0, 64'h0,    0, 0, 64'h0,    11, 0, 64'h0,    16, 64'h2015);
        tbl[24] = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  0, 64'h0,    16, 64'h2020);
        tbl[25] = v(0, 0, 64'h0,    0, 0, 64'h0,    0,  1, 64'h2030, 16, 64'h2020);

        // Reset and release.
        repeat (2) @(negedge clk);
        check_state("reset", 1'b0, 64'h0, 0, RST_PC);
        rstn = 1'b1;
        check_state("release", 1'b0, 64'h0, 0, RST_PC);
        @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            check_state($sformatf("row%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].ec, tbl[i].epc);
            apply(tbl[i].rdy, tbl[i].rsp, tbl[i].rline, tbl[i].st, tbl[i].fl, tbl[i].fpc, tbl[i].cons);
        end

        // Request held while memory is not ready, then redirected.
        for (int i = 0; i < 5; i++) begin
            chk("hold.valid", 128'(imem_req_valid), 128'(1));
            chk("hold.addr", 128'(imem_req_addr), 128'(64'h2030));
            apply(0, 0, 0, 0, 0, 0, 0);
        end
        apply(0, 0, 0, 0, 1, 64'h3005, 0);
        check_state("flush_req", 1'b1, 64'h3000, 0, 64'h3005);
        apply(1, 0, 0, 0, 0, 0, 0);
        check_state("wait", 1'b0, 64'h0, 0, 64'h3005);

        // Flush while waiting; the stale response arrives two cycles later.
        apply(0, 0, 0, 0, 1, 64'h2008, 0);
        check_state("drop", 1'b0, 64'h0, 0, 64'h2008);
        apply(0, 0, 0, 0, 0, 0, 0);
        check_state("drop2", 1'b0, 64'h0, 0, 64'h2008);
        apply(0, 1, 64'h3000, 0, 0, 0, 0);
        check_state("after_drop", 1'b1, 64'h2000, 0, 64'h2008);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 64'h2000, 0, 0, 0, 0);
        check_state("refill", 1'b0, 64'h0, 8, 64'h2008);

        // Stall with a consume request while the prefetcher fills to 32 bytes.
        apply(0, 0, 0, 0, 0, 0, 0);
        check_state("req2010", 1'b1, 64'h2010, 8, 64'h2008);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 64'h2010, 0, 0, 0, 8);
        check_state("cons_app", 1'b0, 64'h0, 16, 64'h2010);
        apply(0, 0, 0, 0, 0, 0, 0);
        check_state("req2020", 1'b1, 64'h2020, 16, 64'h2010);
        apply(1, 0, 0, 1, 0, 0, 4);
        check_state("stall1", 1'b0, 64'h0, 16, 64'h2010);
        apply(0, 1, 64'h2020, 1, 0, 0, 4);
        check_state("stall2", 1'b0, 64'h0, 16, 64'h2010);
        apply(0, 0, 0, 1, 0, 0, 4);
        check_state("stall3", 1'b0, 64'h0, 16, 64'h2010);
        apply(0, 0, 0, 0, 0, 0, 16);
        check_state("full32", 1'b0, 64'h0, 16, 64'h2020);
        apply(0, 0, 0, 0, 0, 0, 0);
        check_state("req2030", 1'b1, 64'h2030, 16, 64'h2020);

        // Address wrap at the top of the 64-bit space.
        apply(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        check_state("wrap_req", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, 0);
        check_state("wrap_fill", 1'b0, 64'h0, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        apply(0, 0, 0, 0, 0, 0, 0);
        check_state("wrap_addr", 1'b1, 64'h0, 2, 64'hFFFF_FFFF_FFFF_FFFE);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 64'h0, 0, 0, 0, 0);
        check_state("wrap_fill2", 1'b0, 64'h0, 16, 64'hFFFF_FFFF_FFFF_FFFE);
        apply(0, 0, 0, 0, 0, 0, 4);
        check_state("wrap_pc", 1'b0, 64'h0, 14, 64'h2);
        apply(0, 0, 0, 0, 0, 0, 0);
        check_state("req10", 1'b1, 64'h10, 14, 64'h2);
        apply(1, 0, 0, 0, 0, 0, 0);
        check_state("wait10", 1'b0, 64'h0, 14, 64'h2);

        // Asynchronous reset in the middle of an outstanding request.
        apply_idle();
        #2 rstn = 1'b0;
        #1 check_state("async_rst", 1'b0, 64'h0, 0, RST_PC);
        @(negedge clk);
        rstn = 1'b1;

        // Randomized traffic against the byte-queue model.
        q.delete();
        m_pc = RST_PC; m_faddr = {RST_PC[63:4], 4'h0}; m_skip = RST_PC[3:0];
        m_out = 0; m_stale = 0; mem_busy = 0; mem_dly = 0; idle_run = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n  = q.size();
            ec = (n > 16) ? 16 : n;
            eb = '0;
            for (int k = 0; k < ec; k++) eb[8*k +: 8] = q[k];
            chk("rnd.count", 128'(fet_count), 128'(ec));
            chk("rnd.fvalid", 128'(fet_valid), 128'(ec != 0));
            chk("rnd.pc", 128'(fet_pc), 128'(m_pc));
            chk("rnd.bytes", fet_bytes, eb);
            if (imem_req_valid) chk("rnd.req_addr", 128'(imem_req_addr), 128'(m_faddr));
            if (m_out) chk("rnd.req_while_out", 128'(imem_req_valid), 128'(0));
            if (!imem_req_valid && !m_out && n <= 16) idle_run++; else idle_run = 0;
            if (idle_run > 2) begin
                chk("rnd.req_stuck", 128'(imem_req_valid), 128'(1));
                idle_run = 0;
            end

            st   = ($urandom % 4) == 0;
            fl   = ($urandom % 16) == 0;
            fpc  = ($urandom % 2) ? {$urandom, $urandom}
                                  : (64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255)));
            cons = $urandom_range(0, 16);
            rdy  = ($urandom % 3) != 0;
            rsp  = 0;
            if (mem_busy) begin
                if (mem_dly == 0) begin
                    rsp = 1;
                    mem_busy = 0;
                end else begin
                    mem_dly--;
                end
            end
            imem_req_ready  = rdy;
            imem_resp_valid = rsp;
            imem_resp_data  = rsp ? line_data(mem_addr) : {$urandom, $urandom, $urandom, $urandom};
            stall           = st;
            flush           = fl;
            flush_pc        = fpc;
            fet_consume     = 5'(cons);

            hs = imem_req_valid && rdy;
            if (hs) begin
                mem_busy = 1;
                mem_addr = imem_req_addr;
                mem_dly  = $urandom_range(0, 2);
            end

            if (fl) begin
                q.delete();
                m_pc = fpc; m_faddr = {fpc[63:4], 4'h0}; m_skip = fpc[3:0];
                if (rsp) m_out = 0;
                else if (m_out) m_stale = 1;
                if (hs) begin m_out = 1; m_stale = 1; end
            end else begin
                c = st ? 0 : ((cons > ec) ? ec : cons);
                repeat (c) void'(q.pop_front());
                m_pc = m_pc + 64'(c);
                if (rsp) begin
                    if (!m_stale) begin
                        for (int k = int'(m_skip); k < 16; k++) q.push_back(memb(m_faddr + 64'(k)));
                        m_faddr = m_faddr + 64'd16;
                        m_skip  = 4'h0;
                    end
                    m_out = 0; m_stale = 0;
                end
                if (hs) begin m_out = 1; m_stale = 0; end
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Return all inputs to quiet values without advancing time.
    task automatic apply_idle();
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
        stall = 0; flush = 0; flush_pc = '0; fet_consume = '0;
    endtask

endmodule
